k_csa_accum_ctrl: RTL

- Sequencer for one 17-bit 3:2 carry-save compressor; accumulates a variable-length group of operands in redundant (sum, carry) form, one operand per cycle, with no carry propagation inside the loop.
- On the group's last operand, runs a single carry-propagate add and presents the result on a valid/ready output port.
- Sits between the operand source and downstream modular-reduction logic.
- Result is modulo 2^W.

---
 rtl/k_csa_pkg.sv | 21 ++
 rtl/k_csa_w.sv | 33 +++
 rtl/k_csa_accum_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/k_csa_pkg.sv
// Shared types and helpers for the carry-save accumulator controller.
// K_CSA_ACCUM_CTRL_CPA_PIPE_EN selects the two-stage resolve states in the top.
package k_csa_pkg;

    localparam int unsigned DefW    = 17;
    localparam int unsigned DefCntW = 8;

    typedef enum logic [2:0] {
        StIdle,
        StAccum,
        StResolve,
        StResolveLo,
        StResolveHi,
        StOut
    } state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/k_csa_w.sv
// Combinational W-bit 3:2 carry-save compressor; the carry vector is shifted left by one
// and the top majority bit falls off, so sum + car == a + b + c modulo 2^W.
module k_csa_w
    import k_csa_pkg::*;
#(
    parameter int unsigned W = DefW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] car
);

    logic [W-1:0] maj;

    always_comb begin
        maj = '0;
        for (int i = 0; i < int'(W); i++) begin
            maj[i] = maj3(a[i], b[i], c[i]);
        end
    end

    assign sum = a ^ b ^ c;
    assign car = {maj[W-2:0], 1'b0};

    // Clock/reset exist only for interface uniformity; the MSB majority is dropped mod 2^W.
    logic unused;
    assign unused = ^{clk, rst, maj[W-1]};

endmodule

// File: rtl/k_csa_accum_ctrl.sv
// Accumulates a group of operands in carry-save form and resolves them with one CPA.
// Define K_CSA_ACCUM_CTRL_CPA_PIPE_EN to split the CPA into low/high halves (one extra cycle).
module k_csa_accum_ctrl
    import k_csa_pkg::*;
#(
    parameter int unsigned W     = DefW,
    parameter int unsigned CNT_W = DefCntW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             busy
);

`ifdef K_CSA_ACCUM_CTRL_CPA_PIPE_EN
    localparam int unsigned LoW = W / 2;
    localparam int unsigned HiW = W - LoW;
    localparam state_e ResolveFirst = StResolveLo;
`else
    localparam state_e ResolveFirst = StResolve;
`endif

    state_e           state_q, state_d;
    logic [W-1:0]     sum_q, sum_d;
    logic [W-1:0]     car_q, car_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic [W-1:0]     csa_sum, csa_car;
    logic             in_xfer;
    logic [CNT_W-1:0] cnt_inc;

`ifdef K_CSA_ACCUM_CTRL_CPA_PIPE_EN
    logic             lo_carry_q, lo_carry_d;
    logic [LoW:0]     lo_add;
    logic [HiW-1:0]   hi_add;

    assign lo_add = {1'b0, sum_q[LoW-1:0]} + {1'b0, car_q[LoW-1:0]};
    assign hi_add = sum_q[W-1:LoW] + car_q[W-1:LoW] + HiW'(lo_carry_q);
`endif

    k_csa_w #(
        .W(W)
    ) u_csa (
        .clk(1'b0),
        .rst(1'b0),
        .a  (sum_q),
        .b  (car_q),
        .c  (in_data),
        .sum(csa_sum),
        .car(csa_car)
    );

    assign in_ready  = (state_q == StIdle) || (state_q == StAccum);
    assign in_xfer   = in_valid && in_ready;
    assign out_valid = (state_q == StOut);
    assign busy      = (state_q != StIdle);
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        car_d       = car_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
`ifdef K_CSA_ACCUM_CTRL_CPA_PIPE_EN
        lo_carry_d  = lo_carry_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_xfer) begin
                    sum_d   = in_data;
                    car_d   = '0;
                    cnt_d   = CNT_W'(1);
                    state_d = in_last ? ResolveFirst : StAccum;
                end
            end
            StAccum: begin
                if (in_xfer) begin
                    sum_d = csa_sum;
                    car_d = csa_car;
                    cnt_d = cnt_inc;
                    if (in_last) begin
                        state_d = ResolveFirst;
                    end
                end
            end
`ifdef K_CSA_ACCUM_CTRL_CPA_PIPE_EN
            StResolveLo: begin
                out_data_d[LoW-1:0] = lo_add[LoW-1:0];
                lo_carry_d          = lo_add[LoW];
                state_d             = StResolveHi;
            end
            StResolveHi: begin
                out_data_d[W-1:LoW] = hi_add;
                out_count_d         = cnt_q;
                state_d             = StOut;
            end
`else
            StResolve: begin
                out_data_d  = sum_q + car_q;
                out_count_d = cnt_q;
                state_d     = StOut;
            end
`endif
            StOut: begin
                if (out_ready) begin
                    sum_d   = '0;
                    car_d   = '0;
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            sum_q       <= '0;
            car_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
`ifdef K_CSA_ACCUM_CTRL_CPA_PIPE_EN
            lo_carry_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            car_q       <= car_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
`ifdef K_CSA_ACCUM_CTRL_CPA_PIPE_EN
            lo_carry_q  <= lo_carry_d;
`endif
        end
    end

endmodule
